// File: rtl/tron_game_engine.sv
// Two-player light-cycle game engine: trail memory, move/collision FSM and
// a two-stage pixel colour path.
module tron_game_engine #(
    parameter int unsigned CELL_SHIFT  = 3,
    parameter int unsigned GRID_W      = 100,
    parameter int unsigned GRID_H      = 75,
    parameter int unsigned V_ACTIVE    = 600,
    parameter int unsigned MOVE_FRAMES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic       blank,
    input  logic       start,
    input  logic [1:0] p1_dir,
    input  logic [1:0] p2_dir,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [1:0] game_state,
    output logic [1:0] winner
);
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned AW    = 13;
    localparam int unsigned XW    = $clog2(GRID_W);
    localparam int unsigned YW    = $clog2(GRID_H);
    localparam int unsigned FW    = $clog2(MOVE_FRAMES + 1);
    localparam int unsigned P1_X0 = 10;
    localparam int unsigned P2_X0 = 89;
    localparam int unsigned Y0    = 37;

    // Upper two bits of every encoding are the visible game_state.
    typedef enum logic [4:0] {
        S_CLEAR  = 5'b00_000,
        S_CLR_P1 = 5'b00_001,
        S_CLR_P2 = 5'b00_010,
        S_READY  = 5'b01_000,
        S_RUN    = 5'b10_000,
        S_LATCH  = 5'b10_001,
        S_RD1    = 5'b10_010,
        S_RD2    = 5'b10_011,
        S_DECIDE = 5'b10_100,
        S_WR1    = 5'b10_101,
        S_WR2    = 5'b10_110,
        S_OVER   = 5'b11_000
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   clr_addr_q;
    logic [FW-1:0]   frame_cnt_q;
    logic [1:0]      winner_q;
    logic            start_q, tick_cond_q;
    logic [XW-1:0]   hx1_q, hx2_q, nx1_q, nx2_q;
    logic [YW-1:0]   hy1_q, hy2_q, ny1_q, ny2_q;
    logic [1:0]      dir1_q, dir2_q, cell1_q;
    logic            oob1_q, oob2_q;
    logic [AW-1:0]   addr1_q, addr2_q;

    logic [1:0]      trail_mem [CELLS];
    logic [1:0]      a_rdata_q;
    logic            a_we, a_re;
    logic [AW-1:0]   a_addr;
    logic [1:0]      a_wdata;

    logic [AW-1:0]   pix_addr_q;
    logic            blank_q;
    logic [1:0]      pix_cell_c;

    logic [1:0]      d1_c, d2_c;
    logic            oob1_c, oob2_c, same_c, crash1_c, crash2_c;
    logic [XW-1:0]   nx1_c, nx2_c;
    logic [YW-1:0]   ny1_c, ny2_c;
    logic            tick_cond_c, tick_c, start_rise_c;

    // A request for the exact reverse heading keeps the current heading.
    function automatic logic [1:0] steer(input logic [1:0] cur, input logic [1:0] req);
        return (req == (cur ^ 2'b10)) ? cur : req;
    endfunction

    // Next cell plus out-of-range flag; edges are flagged before any arithmetic.
    function automatic logic [XW+YW:0] next_cell(input logic [XW-1:0] x,
                                                 input logic [YW-1:0] y,
                                                 input logic [1:0]    d);
        logic          oob;
        logic [XW-1:0] nx;
        logic [YW-1:0] ny;
        oob = 1'b0;
        nx  = x;
        ny  = y;
        case (d)
            2'b00: if (y == '0) oob = 1'b1; else ny = y - YW'(1);
            2'b01: if (x == XW'(GRID_W - 1)) oob = 1'b1; else nx = x + XW'(1);
            2'b10: if (y == YW'(GRID_H - 1)) oob = 1'b1; else ny = y + YW'(1);
            default: if (x == '0) oob = 1'b1; else nx = x - XW'(1);
        endcase
        return {oob, nx, ny};
    endfunction

    // Steering, next-cell, tick/start edge and collision decode.
    always_comb begin
        d1_c = steer(dir1_q, p1_dir);
        d2_c = steer(dir2_q, p2_dir);
        {oob1_c, nx1_c, ny1_c} = next_cell(hx1_q, hy1_q, d1_c);
        {oob2_c, nx2_c, ny2_c} = next_cell(hx2_q, hy2_q, d2_c);
        tick_cond_c  = (row == 10'(V_ACTIVE)) && (col == '0);
        tick_c       = tick_cond_c && !tick_cond_q;
        start_rise_c = start && !start_q;
        same_c   = !oob1_q && !oob2_q && (addr1_q == addr2_q);
        crash1_c = oob1_q || (cell1_q != 2'b00) || same_c;
        crash2_c = oob2_q || (a_rdata_q != 2'b00) || same_c;
    end

    // Engine port of the trail memory, steered by the current state.
    always_comb begin
        a_we    = 1'b0;
        a_re    = 1'b0;
        a_addr  = clr_addr_q;
        a_wdata = 2'b00;
        case (state_q)
            S_CLEAR:  a_we = 1'b1;
            S_CLR_P1: begin a_we = 1'b1; a_addr = AW'(Y0 * GRID_W + P1_X0); a_wdata = 2'b01; end
            S_CLR_P2: begin a_we = 1'b1; a_addr = AW'(Y0 * GRID_W + P2_X0); a_wdata = 2'b10; end
            S_RD1:    begin a_re = !oob1_q; a_addr = addr1_q; end
            S_RD2:    begin a_re = !oob2_q; a_addr = addr2_q; end
            S_WR1:    begin a_we = 1'b1; a_addr = addr1_q; a_wdata = 2'b01; end
            S_WR2:    begin a_we = 1'b1; a_addr = addr2_q; a_wdata = 2'b10; end
            default:  ;
        endcase
    end

    // Trail memory port A: write, synchronous read.
    always_ff @(posedge clock) begin
        if (a_we) trail_mem[a_addr] <= a_wdata;
        if (a_re) a_rdata_q <= trail_mem[a_addr];
    end

    // Game FSM: clear, ready, run/step sequence, over.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            frame_cnt_q <= '0;
            winner_q    <= 2'b00;
            start_q     <= 1'b0;
            tick_cond_q <= 1'b0;
            hx1_q <= XW'(P1_X0); hy1_q <= YW'(Y0); dir1_q <= 2'b01;
            hx2_q <= XW'(P2_X0); hy2_q <= YW'(Y0); dir2_q <= 2'b11;
            nx1_q <= '0; ny1_q <= '0; nx2_q <= '0; ny2_q <= '0;
            oob1_q <= 1'b0; oob2_q <= 1'b0;
            addr1_q <= '0; addr2_q <= '0; cell1_q <= 2'b00;
        end else begin
            start_q     <= start;
            tick_cond_q <= tick_cond_c;
            case (state_q)
                S_CLEAR: begin
                    if (clr_addr_q == AW'(CELLS - 1)) begin
                        clr_addr_q <= '0;
                        state_q    <= S_CLR_P1;
                    end else begin
                        clr_addr_q <= clr_addr_q + AW'(1);
                    end
                end
                S_CLR_P1: state_q <= S_CLR_P2;
                S_CLR_P2: begin
                    hx1_q <= XW'(P1_X0); hy1_q <= YW'(Y0); dir1_q <= 2'b01;
                    hx2_q <= XW'(P2_X0); hy2_q <= YW'(Y0); dir2_q <= 2'b11;
                    state_q <= S_READY;
                end
                S_READY: begin
                    if (start_rise_c) begin
                        frame_cnt_q <= '0;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick_c) begin
                        if (frame_cnt_q == FW'(MOVE_FRAMES - 1)) begin
                            frame_cnt_q <= '0;
                            state_q     <= S_LATCH;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FW'(1);
                        end
                    end
                end
                S_LATCH: begin
                    dir1_q  <= d1_c;
                    dir2_q  <= d2_c;
                    nx1_q   <= nx1_c; ny1_q <= ny1_c; oob1_q <= oob1_c;
                    nx2_q   <= nx2_c; ny2_q <= ny2_c; oob2_q <= oob2_c;
                    addr1_q <= AW'(ny1_c) * AW'(GRID_W) + AW'(nx1_c);
                    addr2_q <= AW'(ny2_c) * AW'(GRID_W) + AW'(nx2_c);
                    state_q <= S_RD1;
                end
                S_RD1: state_q <= S_RD2;
                S_RD2: begin
                    cell1_q <= a_rdata_q;
                    state_q <= S_DECIDE;
                end
                S_DECIDE: begin
                    if (crash1_c || crash2_c) begin
                        winner_q <= {crash1_c, crash2_c};
                        state_q  <= S_OVER;
                    end else begin
                        state_q <= S_WR1;
                    end
                end
                S_WR1: begin
                    hx1_q <= nx1_q; hy1_q <= ny1_q;
                    state_q <= S_WR2;
                end
                S_WR2: begin
                    hx2_q <= nx2_q; hy2_q <= ny2_q;
                    state_q <= S_RUN;
                end
                S_OVER: begin
                    if (start_rise_c) begin
                        winner_q <= 2'b00;
                        state_q  <= S_CLEAR;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    // Display port B lookup; addresses past the grid read as empty.
    always_comb begin
        pix_cell_c = (pix_addr_q < AW'(CELLS)) ? trail_mem[pix_addr_q] : 2'b00;
    end

    // Two-stage pixel pipeline: address/blank, then colour.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pix_addr_q <= '0;
            blank_q    <= 1'b1;
            red <= 8'h00; green <= 8'h00; blue <= 8'h00;
        end else begin
            pix_addr_q <= AW'(row >> CELL_SHIFT) * AW'(GRID_W) + AW'(col >> CELL_SHIFT);
            blank_q    <= blank;
            if (blank_q || (state_q[4:3] == 2'b00)) begin
                red <= 8'h00; green <= 8'h00; blue <= 8'h00;
            end else begin
                case (pix_cell_c)
                    2'b01:   begin red <= 8'h00; green <= 8'hFF; blue <= 8'hFF; end
                    2'b10:   begin red <= 8'hFF; green <= 8'h80; blue <= 8'h00; end
                    default: begin red <= 8'h00; green <= 8'h00; blue <= 8'h00; end
                endcase
            end
        end
    end

    assign game_state = state_q[4:3];
    assign winner     = winner_q;

endmodule

// File: doc/tron_game_engine.md
# tron_game_engine

Game-state engine for the two-player light-cycle game. It sits directly upstream of the colour-merge/HDMI stage. It consumes the VGA timing position and the synchronized player controls, and moves both cycles on a cell grid once every MOVE_FRAMES frames. It records trails in an internal dual-port trail memory, detects collisions and declares a winner. Its per-pixel red/green/blue output is OR-merged with the border layer before the HDMI converter.

## Interface
Parameters:
- CELL_SHIFT, 3: log2 of cell size in pixels (8×8 cells)
- GRID_W, 100: cells per row (800 / 8)
- GRID_H, 75: cells per column (600 / 8)
- V_ACTIVE, 600: first non-visible row; the move tick is taken here
- MOVE_FRAMES, 4: frames per move step (≥1)

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  40 MHz pixel clock
- reset_n  in  1  synchronous, active-low reset
- row  in  10  current VGA row
- col  in  10  current VGA column
- blank  in  1  high outside the visible area
- start  in  1  synchronized start button (level; rising edge detected internally)
- p1_dir  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- p2_dir  in  2  same encoding
- red, green, blue  out  8 each  pixel colour, registered
- game_state  out  2  00 CLEAR, 01 READY, 10 RUN, 11 OVER
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

## Operation
Trail memory:
- GRID_W×GRID_H entries of 2 bits: 00 empty, 01 P1, 10 P2.
- Port A belongs to the engine (read/write, synchronous read, 1-cycle latency).
- Port B is display read-only. There are no port conflicts.
- Cell address = y*GRID_W + x, 13 bits.

State machine (game_state shows the major state):
- CLEAR: address counter walks 0..GRID_W*GRID_H-1, writing 00 once per cycle. It then writes the P1 head and the P2 head (two cycles) and goes to READY.
- Initial heads: P1 at (10,37) facing right; P2 at (89,37) facing left.
- READY: on start rising edge → RUN. The frame counter clears.
- RUN: frame tick = the single cycle where row==V_ACTIVE and col==0 (edge-qualified, so exactly one tick per frame). Every MOVE_FRAMES-th tick starts a step.
- Step sub-sequence:
  - LATCH: take the new direction for each player. A request for the exact reverse of the current heading is ignored and the heading is kept. Compute each next cell.
  - RD1: read P1's next cell.
  - RD2: read P2's next cell.
  - DECIDE: a player crashes if its next cell is outside 0..GRID_W-1 / 0..GRID_H-1, or is non-empty. Both players targeting the same cell means both crash.
  - WR1/WR2: only if no crash. Write 01/10 at the new heads, update the head registers, return to RUN.
- Out-of-range next cells are not read. The x=0 moving left case and the y=0 moving up case must be flagged before subtraction and must never wrap.
- Crash outcome: winner = 01 if only P2 crashed, 10 if only P1 crashed, 11 if both crashed. The FSM then goes to OVER and no heads move on a crash step.
- OVER: freeze. On start rising edge → CLEAR with winner←00.
- start edges are ignored in CLEAR and RUN.
- reset_n low in any state, including mid-CLEAR or mid-step: next state is CLEAR with the address counter at 0, winner 00 and the frame counter at 0. Clearing restarts from cell 0.

Display path:
- Cell index = (row>>CELL_SHIFT)*GRID_W + (col>>CELL_SHIFT).
- Colour map: 01 → (00,FF,FF) cyan; 10 → (FF,80,00) orange; 00 → black.
- Output is forced to black when delayed blank=1 or game_state=CLEAR.

## Timing
- Reset values: red/green/blue 0, game_state 00, winner 00.
- Display latency is exactly 2 clocks from row/col/blank to red/green/blue:
  - stage 1 registers the address and blank;
  - stage 2 registers the colour.
- HS/VS must be delayed 2 clocks downstream to align with the colour.
- CLEAR duration is GRID_W*GRID_H + 2 cycles (7502 by default). READY is entered on the following cycle.
- A step takes 6 cycles from the tick and completes inside vertical blank, so trail writes are never visible mid-frame.
- winner and game_state = OVER assert the cycle after DECIDE.
- Directions are sampled only in LATCH. Changes between steps are not queued; the last value wins.

## Test plan
- Reset then clear: hold reset_n=0 for 2 cycles, release → game_state=00 for 7502 cycles, then 01. Every cell reads 00 except (10,37)=01 and (89,37)=10.
- Straight run: start pulse, dirs held 01/11, MOVE_FRAMES=4 → after 8 frames P1 head=(12,37), P2 head=(87,37). The trail cells are coloured cyan/orange at pixels (96..103, 296..303) etc. with 2-clock latency.
- Reverse ignored: P1 heading right, p1_dir=11 at a step → P1 continues to x+1; a subsequent p1_dir=00 turns it up (y−1).
- Wall crash: P1 driven up from y=37 for 38 steps → on the step at y=0, winner=10, game_state=11, no cell at y=−1 written, and no address wrap to 8191.
- Head-on/draw: both players converge on the same empty cell in one step → winner=11. Separately, P2 steering into P1's trail → winner=01.
- Mid-step reset: assert reset_n=0 during RD2 → next cycle game_state=00, winner=00, and clearing restarts from address 0. A start press in OVER → CLEAR → READY with winner 00.
